// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel button debouncer with edge pulses and optional auto-repeat
// Optional feature macro: BUTTON_CONDITIONER_AUTO_REPEAT_EN (enables the rep pulse generator)
module button_conditioner #(
   parameter int N            = 5,
   parameter int TICK_DIV     = 1000000,
   parameter int SETTLE_TICKS = 3,
   parameter int REPEAT_DELAY = 30,
   parameter int REPEAT_RATE  = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] sw,
   output logic [N-1:0] db,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall,
   output logic [N-1:0] rep
);

   // One counter width covers the lock length and both repeat intervals.
   localparam int MAX_SR = (SETTLE_TICKS > REPEAT_DELAY) ? SETTLE_TICKS : REPEAT_DELAY;
   localparam int MAX_T  = (MAX_SR > REPEAT_RATE) ? MAX_SR : REPEAT_RATE;
   localparam int CW     = $clog2(MAX_T + 1);
   localparam int PW     = $clog2(TICK_DIV);

   localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_TICKS - 1);

   typedef enum logic [1:0] {
      ZERO         = 2'd0,
      PRESS_LOCK   = 2'd1,
      ONE          = 2'd2,
      RELEASE_LOCK = 2'd3
   } state_t;

   logic [N-1:0]  sync1_q, sync1_d;
   logic [N-1:0]  sync2_q, sync2_d;
   logic [N-1:0]  s;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick;

   state_t        state_q [N];
   state_t        state_d [N];
   logic [CW-1:0] cnt_q   [N];
   logic [CW-1:0] cnt_d   [N];

   logic [N-1:0]  db_q, db_d;
   logic [N-1:0]  rise_q, rise_d;
   logic [N-1:0]  fall_q, fall_d;

   // Two-flop synchronizer per channel; the FSMs only ever see the second stage.
   always_comb begin
      sync1_d = sw;
      sync2_d = sync1_q;
      s       = sync2_q;
   end

   // Shared prescaler: tick is high for the single cycle the count sits at its last value.
   always_comb begin
      tick    = (presc_q == PRESC_LAST);
      presc_d = tick ? '0 : presc_q + PW'(1);
   end

   // Per-channel debounce FSM; edges are accepted immediately, then further activity is locked out.
   always_comb begin
      rise_d = '0;
      fall_d = '0;
      db_d   = '0;
      for (int i = 0; i < N; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            ZERO: begin
               if (s[i]) begin
                  state_d[i] = PRESS_LOCK;
                  cnt_d[i]   = '0;
                  rise_d[i]  = 1'b1;
               end
            end
            PRESS_LOCK: begin
               if (tick) begin
                  if (cnt_q[i] == SETTLE_LAST) begin
                     state_d[i] = ONE;
                     cnt_d[i]   = '0;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CW'(1);
                  end
               end
            end
            ONE: begin
               if (!s[i]) begin
                  state_d[i] = RELEASE_LOCK;
                  cnt_d[i]   = '0;
                  fall_d[i]  = 1'b1;
               end
            end
            RELEASE_LOCK: begin
               if (tick) begin
                  if (cnt_q[i] == SETTLE_LAST) begin
                     state_d[i] = ZERO;
                     cnt_d[i]   = '0;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CW'(1);
                  end
               end
            end
            default: begin
               state_d[i] = ZERO;
               cnt_d[i]   = '0;
            end
         endcase
         db_d[i] = (state_d[i] == PRESS_LOCK) || (state_d[i] == ONE);
      end
   end

   // State and output registers; reset drops every channel back to ZERO without pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         presc_q <= '0;
         db_q    <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int i = 0; i < N; i++) begin
            state_q[i] <= ZERO;
            cnt_q[i]   <= '0;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         presc_q <= presc_d;
         db_q    <= db_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         for (int i = 0; i < N; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   assign db   = db_q;
   assign rise = rise_q;
   assign fall = fall_q;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
   localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

   logic [CW-1:0] rcnt_q [N];
   logic [CW-1:0] rcnt_d [N];
   logic [N-1:0]  rphase_q, rphase_d;
   logic [N-1:0]  rep_q, rep_d;

   // Repeat timer: counts ticks while the press is held; the first pulse waits the delay, later ones the rate.
   // The entry cycle itself is excluded, so a coincident tick is not counted, matching the lock counter.
   always_comb begin
      rep_d    = '0;
      rphase_d = rphase_q;
      for (int i = 0; i < N; i++) begin
         rcnt_d[i] = rcnt_q[i];
         if (!(((state_q[i] == PRESS_LOCK) || (state_q[i] == ONE)) && db_d[i])) begin
            rcnt_d[i]   = '0;
            rphase_d[i] = 1'b0;
         end else if (tick) begin
            if (!rphase_q[i]) begin
               if (rcnt_q[i] == DELAY_LAST) begin
                  rep_d[i]    = 1'b1;
                  rcnt_d[i]   = '0;
                  rphase_d[i] = 1'b1;
               end else begin
                  rcnt_d[i] = rcnt_q[i] + CW'(1);
               end
            end else begin
               if (rcnt_q[i] == RATE_LAST) begin
                  rep_d[i]  = (state_q[i] == ONE);
                  rcnt_d[i] = '0;
               end else begin
                  rcnt_d[i] = rcnt_q[i] + CW'(1);
               end
            end
         end
      end
   end

   // Repeat registers, cleared with the rest of the channel state.
   always_ff @(posedge clk) begin
      if (reset) begin
         rphase_q <= '0;
         rep_q    <= '0;
         for (int i = 0; i < N; i++) begin
            rcnt_q[i] <= '0;
         end
      end else begin
         rphase_q <= rphase_d;
         rep_q    <= rep_d;
         for (int i = 0; i < N; i++) begin
            rcnt_q[i] <= rcnt_d[i];
         end
      end
   end

   assign rep = rep_q;
`else
   assign rep = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
module tb_button_conditioner;

   localparam int N            = 2;
   localparam int TICK_DIV     = 4;
   localparam int SETTLE_TICKS = 3;
   localparam int REPEAT_DELAY = 5;
   localparam int REPEAT_RATE  = 2;

   typedef struct {
      int           cyc;
      logic [N-1:0] rise;
      logic [N-1:0] fall;
      logic [N-1:0] rep;
   } ev_t;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] sw    = '0;
   logic [N-1:0] db, rise, fall, rep;

   int           cyc       = 0;
   int           n_checks  = 0;
   int           n_fails   = 0;
   int           rst_edge  = 0;
   logic         rst_seen  = 1'b1;
   logic [N-1:0] exp_db    = '0;
   ev_t          sb [$];

   logic [N-1:0] m_r, m_f, m_p;
   bit           m_due;
   ev_t          m_e;

   button_conditioner #(
      .N(N), .TICK_DIV(TICK_DIV), .SETTLE_TICKS(SETTLE_TICKS),
      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
   ) dut (
      .clk(clk), .reset(reset), .sw(sw), .db(db), .rise(rise), .fall(fall), .rep(rep)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= reset;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s at cycle %0d: got %b, required %b", name, cyc, act, req);
      end
   endtask

   // nth prescaler tick edge strictly after edge p, counted from the last reset edge
   function automatic int tick_after(input int p, input int n);
      return rst_edge + TICK_DIV * ((p - rst_edge) / TICK_DIV + 1) + TICK_DIV * (n - 1);
   endfunction

   task automatic push_ev(input int c, input logic [N-1:0] r, input logic [N-1:0] f, input logic [N-1:0] p);
      ev_t e;
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].cyc == c) begin
            e      = sb[i];
            e.rise = e.rise | r;
            e.fall = e.fall | f;
            e.rep  = e.rep | p;
            sb[i]  = e;
            return;
         end
         if (sb[i].cyc > c) begin
            e.cyc = c; e.rise = r; e.fall = f; e.rep = p;
            sb.insert(i, e);
            return;
         end
      end
      e.cyc = c; e.rise = r; e.fall = f; e.rep = p;
      sb.push_back(e);
   endtask

   // press accepted at edge e, release accepted at edge f
   task automatic push_hold(input int ch, input int e, input int f);
      logic [N-1:0] m;
      m = N'(1) << ch;
      push_ev(e, m, '0, '0);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
      begin
         int n;
         n = REPEAT_DELAY;
         while (tick_after(e, n) < f) begin
            push_ev(tick_after(e, n), '0, '0, m);
            n += REPEAT_RATE;
         end
      end
`endif
      push_ev(f, '0, m, '0);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitor: pops the event due this cycle, checks pulses whenever any is due or present, and tracks db.
   always @(negedge clk) begin
      m_r = '0; m_f = '0; m_p = '0; m_due = 1'b0;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         m_e = sb.pop_front();
         check("sb_stale", 8'(m_e.cyc), 8'(cyc));
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         m_e   = sb.pop_front();
         m_r   = m_e.rise;
         m_f   = m_e.fall;
         m_p   = m_e.rep;
         m_due = 1'b1;
      end
      if (rst_seen) exp_db = '0;
      else          exp_db = (exp_db | m_r) & ~m_f;
      if (m_due || rise != '0 || fall != '0 || rep != '0) begin
         check("rise", 8'(rise), 8'(m_r));
         check("fall", 8'(fall), 8'(m_f));
         check("rep",  8'(rep),  8'(m_p));
      end
      check("db", 8'(db), 8'(exp_db));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int p, e, l, e2;
      reset = 1'b1;
      sw    = '0;
      wait_cyc(3);
      check("reset_outs", {db, rise, fall, rep}, 8'h00);
      reset    = 1'b0;
      rst_edge = 3;

      // single press then release after the lock; channel 1 idle
      wait_cyc(6);
      p = cyc; sw = 2'b01; e = p + 3;
      l = tick_after(e, SETTLE_TICKS);
      push_hold(0, e, l + 4);
      wait_cyc(l + 1); sw = 2'b00;
      wait_cyc(tick_after(l + 4, SETTLE_TICKS) + 2);

      // bounce during the press lock is ignored
      p = cyc; sw = 2'b01; e = p + 3;
      l = tick_after(e, SETTLE_TICKS);
      push_hold(0, e, l + 4);
      wait_cyc(p + 2); sw = 2'b00;
      wait_cyc(p + 4); sw = 2'b01;
      wait_cyc(p + 6); sw = 2'b00;
      wait_cyc(p + 8); sw = 2'b01;
      wait_cyc(l + 1); sw = 2'b00;
      wait_cyc(tick_after(l + 4, SETTLE_TICKS) + 2);

      // release inside the lock is taken one cycle after the lock ends
      p = cyc; sw = 2'b01; e = p + 3;
      l = tick_after(e, SETTLE_TICKS);
      push_hold(0, e, l + 1);
      wait_cyc(p + 5); sw = 2'b00;
      wait_cyc(tick_after(l + 1, SETTLE_TICKS) + 2);

      // both channels together, channel 1 released first
      p = cyc; sw = 2'b11; e = p + 3;
      push_hold(1, e, p + 43);
      push_hold(0, e, p + 53);
      wait_cyc(p + 40); sw = 2'b01;
      wait_cyc(p + 50); sw = 2'b00;
      wait_cyc(tick_after(p + 53, SETTLE_TICKS) + 2);

      // long hold for auto-repeat
      p = cyc; sw = 2'b01; e = p + 3;
      push_hold(0, e, p + 63);
      wait_cyc(p + 60); sw = 2'b00;
      wait_cyc(tick_after(p + 63, SETTLE_TICKS) + 2);

      // reset during the press lock with the button held
      p = cyc; sw = 2'b01; e = p + 3;
      push_ev(e, 2'b01, '0, '0);
      wait_cyc(e + 2); reset = 1'b1;
      wait_cyc(e + 4); reset = 1'b0;
      rst_edge = e + 4;
      e2 = rst_edge + 3;
      l  = tick_after(e2, SETTLE_TICKS);
      push_hold(0, e2, l + 4);
      wait_cyc(l + 1); sw = 2'b00;
      wait_cyc(tick_after(l + 4, SETTLE_TICKS) + 4);

      check("sb_drained", 8'(sb.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
